// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe board definitions: tile masks, line table, fallback order
// and the move-selector FSM encoding. Tile t lives at board bit 8-t.
package tictactoe_pkg;

    localparam int N_TILES = 9;
    localparam int N_LINES = 8;

    typedef logic [N_TILES-1:0] board_t;

    localparam board_t TILE_MASK [N_TILES] = '{
        9'b100_000_000, 9'b010_000_000, 9'b001_000_000,
        9'b000_100_000, 9'b000_010_000, 9'b000_001_000,
        9'b000_000_100, 9'b000_000_010, 9'b000_000_001
    };

    // Rows, then columns, then the two diagonals; scan order is significant.
    localparam board_t LINE_MASK [N_LINES] = '{
        9'b111_000_000, 9'b000_111_000, 9'b000_000_111,
        9'b100_100_100, 9'b010_010_010, 9'b001_001_001,
        9'b100_010_001, 9'b001_010_100
    };

    // Centre first, then corners, then edges.
    localparam logic [3:0] FALLBACK_ORDER [N_TILES] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WIN_SCAN   = 3'd1,
        BLOCK_SCAN = 3'd2,
        FALLBACK   = 3'd3,
        DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/ai_move_sel_if.sv
// Request/response bundle between the game controller and the AI move selector.
interface ai_move_sel_if;
    import tictactoe_pkg::*;

    logic   start;
    board_t X_state;
    board_t O_state;
    board_t AIMove;
    logic   move_valid;
    logic   busy;
    logic   no_move;

    modport master (
        output start, X_state, O_state,
        input  AIMove, move_valid, busy, no_move
    );

    modport slave (
        input  start, X_state, O_state,
        output AIMove, move_valid, busy, no_move
    );

endinterface

// File: rtl/ttt_line_eval.sv
// Combinational check of one line: does "own" hold two of its tiles with the
// third empty? Returns the empty tile one-hot when it does, zero otherwise.
module ttt_line_eval
    import tictactoe_pkg::*;
(
    input  board_t line_mask,
    input  board_t own,
    input  board_t occupied,
    output logic   hit,
    output board_t tile
);

    board_t own_in_line;
    board_t empty_in_line;

    assign own_in_line   = line_mask & own;
    assign empty_in_line = line_mask & ~occupied;

    assign hit  = ($countones(own_in_line) == 2) && ($countones(empty_in_line) == 1);
    assign tile = hit ? empty_in_line : '0;

endmodule

// File: rtl/ai_move_sel.sv
// AI move selector: scans for a winning line, then a blocking line, then falls
// back to a fixed preference order, one line per cycle.
module ai_move_sel
    import tictactoe_pkg::*;
#(
    parameter bit STRATEGY = 1'b1
) (
    input logic         clk,
    input logic         rst,
    ai_move_sel_if.slave bus
);

    state_t     state;
    logic [2:0] idx;
    board_t     x_cap;
    board_t     o_cap;
    board_t     move;
    logic       move_valid;
    logic       busy;
    logic       no_move;

    board_t occupied;
    board_t own;
    logic   line_hit;
    board_t line_tile;
    board_t fb_tile;

    assign occupied = x_cap | o_cap;
    assign own      = (state == BLOCK_SCAN) ? o_cap : x_cap;

    ttt_line_eval u_line_eval (
        .line_mask (LINE_MASK[idx]),
        .own       (own),
        .occupied  (occupied),
        .hit       (line_hit),
        .tile      (line_tile)
    );

    // NOTE: fb_tile gets a default before the loop so no latch is inferred.
    always_comb begin
        fb_tile = '0;
        for (int i = 0; i < N_TILES; i++) begin
            if (fb_tile == '0 && (occupied & TILE_MASK[FALLBACK_ORDER[i]]) == '0)
                fb_tile = TILE_MASK[FALLBACK_ORDER[i]];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            x_cap      <= '0;
            o_cap      <= '0;
            move       <= '0;
            move_valid <= 1'b0;
            busy       <= 1'b0;
            no_move    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_cap   <= bus.X_state;
                        o_cap   <= bus.O_state;
                        move    <= '0;
                        no_move <= 1'b0;
                        busy    <= 1'b1;
                        idx     <= '0;
                        state   <= STRATEGY ? WIN_SCAN : FALLBACK;
                    end
                end
                WIN_SCAN, BLOCK_SCAN: begin
                    if (line_hit) begin
                        move       <= line_tile;
                        move_valid <= 1'b1;
                        state      <= DONE;
                    end else if (idx == 3'd7) begin
                        idx   <= '0;
                        state <= (state == WIN_SCAN) ? BLOCK_SCAN : FALLBACK;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                FALLBACK: begin
                    move       <= fb_tile;
                    no_move    <= (fb_tile == '0);
                    move_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    move_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.AIMove     = move;
    assign bus.move_valid = move_valid;
    assign bus.busy       = busy;
    assign bus.no_move    = no_move;

endmodule

// File: tb/tb_ai_move_sel.sv
// Scoreboard bench for ai_move_sel: hard and easy instances side by side,
// expected moves queued at start and checked when move_valid appears.
module tb_ai_move_sel;
    import tictactoe_pkg::*;

    typedef struct {
        board_t move;
        logic   no_move;
        int     valid_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrors = 0;

    exp_t q_hard[$];
    exp_t q_easy[$];

    ai_move_sel_if if_hard ();
    ai_move_sel_if if_easy ();

    ai_move_sel #(.STRATEGY(1'b1)) dut_hard (.clk(clk), .rst(rst), .bus(if_hard.slave));
    ai_move_sel #(.STRATEGY(1'b0)) dut_easy (.clk(clk), .rst(rst), .bus(if_easy.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && if_hard.move_valid) begin
            if (q_hard.size() == 0) begin
                check("hard_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_hard.pop_front();
                check("hard_move", 32'(if_hard.AIMove), 32'(e.move));
                check("hard_no_move", 32'(if_hard.no_move), 32'(e.no_move));
                check("hard_latency", cyc, e.valid_cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && if_easy.move_valid) begin
            if (q_easy.size() == 0) begin
                check("easy_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_easy.pop_front();
                check("easy_move", 32'(if_easy.AIMove), 32'(e.move));
                check("easy_no_move", 32'(if_easy.no_move), 32'(e.no_move));
                check("easy_latency", cyc, e.valid_cyc);
            end
        end
    end

    // Pulses start for one cycle, then scrambles the board inputs so that any
    // use of live inputs instead of the captured board shows up as a wrong move.
    task automatic issue(input bit hard, input board_t x, input board_t o, input bit push,
                         input board_t exp_move, input logic exp_no, input int lat);
        exp_t e;
        @(negedge clk);
        e.move = exp_move;
        e.no_move = exp_no;
        e.valid_cyc = cyc + lat;
        if (hard) begin
            if_hard.X_state = x; if_hard.O_state = o; if_hard.start = 1'b1;
            if (push) q_hard.push_back(e);
        end else begin
            if_easy.X_state = x; if_easy.O_state = o; if_easy.start = 1'b1;
            if (push) q_easy.push_back(e);
        end
        @(negedge clk);
        if_hard.start = 1'b0;
        if_easy.start = 1'b0;
        if_hard.X_state = ~x; if_hard.O_state = 9'b0;
        if_easy.X_state = ~x; if_easy.O_state = 9'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget && (q_hard.size() != 0 || q_easy.size() != 0); n++)
            @(negedge clk);
        if (q_hard.size() != 0 || q_easy.size() != 0) begin
            check("timeout_pending", 32'(q_hard.size() + q_easy.size()), 32'd0);
            q_hard.delete();
            q_easy.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        if_hard.start = 1'b0; if_hard.X_state = '0; if_hard.O_state = '0;
        if_easy.start = 1'b0; if_easy.X_state = '0; if_easy.O_state = '0;
        repeat (3) @(negedge clk);
        check("rst_aimove", 32'(if_hard.AIMove), 32'd0);
        check("rst_valid", 32'(if_hard.move_valid), 32'd0);
        check("rst_busy", 32'(if_hard.busy), 32'd0);
        check("rst_no_move", 32'(if_hard.no_move), 32'd0);
        check("rst_easy_busy", 32'(if_easy.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Empty board: hard falls through all 16 lines to the centre tile.
        issue(1'b1, 9'b000_000_000, 9'b000_000_000, 1'b1, 9'b000_010_000, 1'b0, 18);
        check("busy_after_start", 32'(if_hard.busy), 32'd1);
        wait_idle(40);
        check("busy_dropped", 32'(if_hard.busy), 32'd0);
        check("aimove_holds", 32'(if_hard.AIMove), 32'(9'b000_010_000));

        // Win on row 0; AIMove must clear to 0 on the accepted start.
        issue(1'b1, 9'b110_000_000, 9'b000_110_000, 1'b1, 9'b001_000_000, 1'b0, 2);
        check("aimove_cleared", 32'(if_hard.AIMove), 32'd0);
        wait_idle(40);

        // Block on row 2.
        issue(1'b1, 9'b100_010_000, 9'b000_000_011, 1'b1, 9'b000_000_100, 1'b0, 12);
        wait_idle(40);

        // Win on column 0 takes priority over an available block on column 2.
        issue(1'b1, 9'b100_100_000, 9'b001_001_000, 1'b1, 9'b000_000_100, 1'b0, 5);
        wait_idle(40);

        // Win on anti-diagonal, the last line scanned.
        issue(1'b1, 9'b001_000_100, 9'b000_000_000, 1'b1, 9'b000_010_000, 1'b0, 9);
        wait_idle(40);

        // Overlapping X/O on the centre counts as X for the main diagonal win.
        issue(1'b1, 9'b100_010_000, 9'b000_010_000, 1'b1, 9'b000_000_001, 1'b0, 8);
        wait_idle(40);

        // Full board: no move, no_move held afterwards.
        issue(1'b1, 9'b101_011_010, 9'b010_100_101, 1'b1, 9'b000_000_000, 1'b1, 18);
        wait_idle(40);
        repeat (3) @(negedge clk);
        check("no_move_holds", 32'(if_hard.no_move), 32'd1);

        // Extra start while busy must be dropped, not queued.
        issue(1'b1, 9'b000_000_000, 9'b000_000_000, 1'b1, 9'b000_010_000, 1'b0, 18);
        check("no_move_cleared", 32'(if_hard.no_move), 32'd0);
        repeat (3) @(negedge clk);
        if_hard.start = 1'b1;
        @(negedge clk);
        if_hard.start = 1'b0;
        wait_idle(40);
        repeat (25) @(negedge clk);

        // Reset mid-scan: aborts with no pulse, then a fresh scan works.
        issue(1'b1, 9'b000_000_000, 9'b000_000_000, 1'b0, 9'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        if_hard.start = 1'b1;
        @(negedge clk);
        if_hard.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(if_hard.busy), 32'd0);
        check("abort_valid", 32'(if_hard.move_valid), 32'd0);
        check("abort_aimove", 32'(if_hard.AIMove), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        issue(1'b1, 9'b000_000_000, 9'b000_000_000, 1'b1, 9'b000_010_000, 1'b0, 18);
        wait_idle(40);

        // Easy strategy: fallback only, latency 2.
        issue(1'b0, 9'b000_010_000, 9'b000_000_000, 1'b1, 9'b100_000_000, 1'b0, 2);
        wait_idle(20);
        issue(1'b0, 9'b110_000_000, 9'b000_000_000, 1'b1, 9'b000_010_000, 1'b0, 2);
        wait_idle(20);
        issue(1'b0, 9'b101_011_010, 9'b010_100_101, 1'b1, 9'b000_000_000, 1'b1, 2);
        wait_idle(20);
        check("easy_busy_dropped", 32'(if_easy.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
